// File: rtl/cla_4.sv
// 4-bit carry-lookahead adder with group propagate/generate and signed overflow.
// REG_OUT selects a one-cycle registered result or a purely combinational one.
module cla_4 #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sout,
  output logic       cout,
  output logic       grp_p,
  output logic       grp_g,
  output logic       ovf,
  output logic       out_valid
);

  // Handshake: valid-only stream. in_valid qualifies a/b/cin in the cycle it is
  // high; out_valid qualifies every result output. There is no ready: one
  // operand set is accepted every cycle and the result registers load always.

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] sum_d;
  logic       grp_p_d;
  logic       grp_g_d;
  logic       ovf_d;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum-of-products on the bit terms and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum_d   = p ^ c[3:0];
  assign grp_p_d = &p;
  assign grp_g_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
  assign ovf_d   = c[4] ^ c[3];

  generate
    if (REG_OUT) begin : g_reg
      logic [3:0] sout_q;
      logic       cout_q;
      logic       grp_p_q;
      logic       grp_g_q;
      logic       ovf_q;
      logic       valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sout_q  <= 4'h0;
          cout_q  <= 1'b0;
          grp_p_q <= 1'b0;
          grp_g_q <= 1'b0;
          ovf_q   <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          sout_q  <= sum_d;
          cout_q  <= c[4];
          grp_p_q <= grp_p_d;
          grp_g_q <= grp_g_d;
          ovf_q   <= ovf_d;
          valid_q <= in_valid;
        end
      end

      assign sout      = sout_q;
      assign cout      = cout_q;
      assign grp_p     = grp_p_q;
      assign grp_g     = grp_g_q;
      assign ovf       = ovf_q;
      assign out_valid = valid_q;
    end else begin : g_comb
      assign sout      = sum_d;
      assign cout      = c[4];
      assign grp_p     = grp_p_d;
      assign grp_g     = grp_g_d;
      assign ovf       = ovf_d;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_cla_4.sv
// Bench for cla_4 (REG_OUT=1): directed table, exhaustive sweep, random stream
// and asynchronous-reset sequences against an arithmetic reference model.
module tb_cla_4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sout;
  logic       cout;
  logic       grp_p;
  logic       grp_g;
  logic       ovf;
  logic       out_valid;

  int tests_run = 0;
  int tests_failed = 0;

  // Packed result layout: {ovf, grp_g, grp_p, cout, sout[3:0]}
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[5];

  cla_4 #(.REG_OUT(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sout     (sout),
    .cout     (cout),
    .grp_p    (grp_p),
    .grp_g    (grp_g),
    .ovf      (ovf),
    .out_valid(out_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] model(input logic [3:0] av, input logic [3:0] bv,
                                       input logic cv);
    int total;
    int sa;
    int sb;
    int ssum;
    logic [4:0] res;
    logic gp;
    logic gg;
    logic ov;
    total = int'(av) + int'(bv) + int'(cv);
    res   = total[4:0];
    sa    = av[3] ? int'(av) - 16 : int'(av);
    sb    = bv[3] ? int'(bv) - 16 : int'(bv);
    ssum  = sa + sb + int'(cv);
    ov    = (ssum > 7) || (ssum < -8);
    gp    = ((av ^ bv) == 4'hF);
    gg    = (int'(av) + int'(bv)) >= 16;
    return {ov, gg, gp, res[4], res[3:0]};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] dut_res();
    return {ovf, grp_g, grp_p, cout, sout};
  endfunction

  // ---------------- driver ----------------
  // Drive one operand set at negedge, check the registered result after posedge.
  task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                      input logic vv, input string name);
    logic [7:0] e;
    @(negedge clk);
    a = av;
    b = bv;
    cin = cv;
    in_valid = vv;
    exp_q.push_back(model(av, bv, cv));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(name, dut_res(), e);
    chk({name, "_valid"}, {7'd0, out_valid}, {7'd0, vv});
    chk({name, "_cout_rel"}, {7'd0, cout}, {7'd0, grp_g | (grp_p & cv)});
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = 4'h0;
    b = 4'h0;
    cin = 1'b0;

    tbl[0] = '{a: 4'b1000, b: 4'b0011, cin: 1'b1, exp: {1'b0, 1'b0, 1'b0, 1'b0, 4'b1100}};
    tbl[1] = '{a: 4'b0001, b: 4'b1010, cin: 1'b1, exp: {1'b0, 1'b0, 1'b0, 1'b0, 4'b1100}};
    tbl[2] = '{a: 4'b1010, b: 4'b0101, cin: 1'b1, exp: {1'b0, 1'b0, 1'b1, 1'b1, 4'b0000}};
    tbl[3] = '{a: 4'b0110, b: 4'b0110, cin: 1'b1, exp: {1'b1, 1'b0, 1'b0, 1'b0, 4'b1101}};
    tbl[4] = '{a: 4'b1001, b: 4'b0100, cin: 1'b1, exp: {1'b0, 1'b0, 1'b0, 1'b0, 4'b1110}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", dut_res(), 8'h00);
    chk("reset_valid", {7'd0, out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, back-to-back
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = tbl[i].a;
      b = tbl[i].b;
      cin = tbl[i].cin;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("table_%0d", i), dut_res(), tbl[i].exp);
      chk($sformatf("table_%0d_valid", i), {7'd0, out_valid}, 8'h01);
    end

    // Exhaustive sweep, one combination per cycle
    for (int i = 0; i < 512; i++) begin
      step(i[3:0], i[7:4], i[8], 1'b1, $sformatf("exh_%0d", i));
    end

    // Random stream with random in_valid; registers load regardless of valid
    for (int i = 0; i < 200; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $sformatf("rnd_%0d", i));
    end

    // Mid-stream asynchronous reset: outputs clear with no clock edge
    step(4'hF, 4'hF, 1'b1, 1'b1, "pre_reset");
    @(negedge clk);
    a = 4'h7;
    b = 4'h9;
    cin = 1'b1;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", dut_res(), 8'h00);
    chk("async_reset_valid", {7'd0, out_valid}, 8'h00);
    @(posedge clk);
    #1;
    chk("reset_held_outputs", dut_res(), 8'h00);
    chk("reset_held_valid", {7'd0, out_valid}, 8'h00);

    // After release, out_valid stays low until a valid operand is sampled
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_release_idle_%0d", i), {7'd0, out_valid}, 8'h00);
    end
    step(4'h3, 4'h4, 1'b0, 1'b1, "first_after_release");
    step(4'h8, 4'h8, 1'b0, 1'b0, "invalid_loads");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
